// File: rtl/mu_pkg.sv
// mu_pkg: shared widths, latency and mulctl encodings for the multiply unit and its issue stage
package mu_pkg;
  localparam int XLEN      = 32;
  localparam int MU_LAT    = 2;
  localparam int TAG_W     = 5;
  localparam int BUF_DEPTH = 4;
  typedef enum logic [1:0] {
    MUL_LO = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mulctl_e;
endpackage

// File: rtl/mu_rsp_fifo.sv
// mu_rsp_fifo: in-order result buffer with separate occupancy count and synchronous clear
module mu_rsp_fifo #(
  parameter int W     = mu_pkg::XLEN + mu_pkg::TAG_W,
  parameter int DEPTH = mu_pkg::BUF_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clr_i,
  input  logic [W-1:0]  din_i,
  output logic [CW-1:0] count_o,
  output logic [W-1:0]  head_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(push_i);
      rd_q  <= rd_q + AW'(pop_i);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end
  always_ff @(posedge clk)
    if (push_i & ~clr_i) mem_q[wr_q] <= din_i;
  assign count_o = cnt_q;
  // Head reads as zero when empty so stale entries never leak onto the response bus
  assign head_o = (cnt_q != '0) ? mem_q[rd_q] : '0;
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !clr_i && cnt_q == CW'(DEPTH)));
endmodule

// File: rtl/mu_issue_ctl.sv
// mu_issue_ctl: issues multiply requests to mu, tracks them through its fixed latency
// and buffers tagged results so writeback can stall a non-stallable multiplier
module mu_issue_ctl #(
  parameter int XLEN      = mu_pkg::XLEN,
  parameter int MU_LAT    = mu_pkg::MU_LAT,
  parameter int TAG_W     = mu_pkg::TAG_W,
  parameter int BUF_DEPTH = mu_pkg::BUF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [1:0]       req_mulctl,
  input  logic [TAG_W-1:0] req_rd,
  input  logic             flush,
  output logic [XLEN-1:0]  mu_a,
  output logic [XLEN-1:0]  mu_b,
  output logic [1:0]       mu_mulctl,
  input  logic [XLEN-1:0]  mu_res,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_data,
  output logic [TAG_W-1:0] rsp_rd,
  output logic             busy
);
  import mu_pkg::*;
  // Stage 0 mirrors the mu operand register; the last stage marks mu_res valid this cycle
  localparam int NS = MU_LAT + 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  logic [NS-1:0]    vld_q;
  logic [TAG_W-1:0] tag_q [NS];
  logic [XLEN-1:0]  mu_a_q, mu_b_q;
  logic [1:0]       mu_mulctl_q;
  logic [CW-1:0]    cnt;
  logic [CW:0]      occ;
  logic             fire, push, pop;
  always_comb begin
    occ = (CW + 1)'(cnt);
    for (int i = 0; i < NS; i++) occ = occ + (CW + 1)'(vld_q[i]);
  end
  // Credits come from registered state only, so a same-cycle pop frees nothing yet
  assign req_ready = rst_n & ~flush & (occ < (CW + 1)'(BUF_DEPTH));
  assign fire      = req_valid & req_ready;
  assign push      = vld_q[NS-1] & ~flush;
  assign pop       = rsp_valid & rsp_ready & ~flush;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= '0;
      mu_a_q      <= '0;
      mu_b_q      <= '0;
      mu_mulctl_q <= MUL_LO;
    end else begin
      vld_q       <= flush ? '0 : {vld_q[NS-2:0], fire};
      mu_a_q      <= fire ? req_a : '0;
      mu_b_q      <= fire ? req_b : '0;
      mu_mulctl_q <= fire ? req_mulctl : MUL_LO;
    end
  end
  always_ff @(posedge clk) begin
    tag_q[0] <= req_rd;
    for (int i = 1; i < NS; i++) tag_q[i] <= tag_q[i-1];
  end
  mu_rsp_fifo #(.W(XLEN + TAG_W), .DEPTH(BUF_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .clr_i   (flush),
    .din_i   ({tag_q[NS-1], mu_res}),
    .count_o (cnt),
    .head_o  ({rsp_rd, rsp_data})
  );
  assign mu_a      = mu_a_q;
  assign mu_b      = mu_b_q;
  assign mu_mulctl = mu_mulctl_q;
  assign rsp_valid = cnt != '0;
  assign busy      = (|vld_q) | rsp_valid;
endmodule

// File: tb/tb_mu_issue_ctl.sv
// tb_mu_issue_ctl: scoreboard bench with a behavioural mu pipeline and directed plus random traffic
module tb_mu_issue_ctl;
  import mu_pkg::*;
  typedef struct {
    logic [XLEN-1:0]  d;
    logic [TAG_W-1:0] rd;
    int               cyc;
  } ent_t;

  logic clk = 0, rst_n = 1, req_valid = 0, flush = 0, rsp_ready = 0;
  logic [XLEN-1:0] req_a = '0, req_b = '0;
  logic [1:0] req_mulctl = '0;
  logic [TAG_W-1:0] req_rd = '0;
  logic req_ready, rsp_valid, busy;
  logic [XLEN-1:0] mu_a, mu_b, mu_res, rsp_data;
  logic [1:0] mu_mulctl;
  logic [TAG_W-1:0] rsp_rd;
  logic [XLEN-1:0] pipe [MU_LAT];
  ent_t q[$], obs[$];
  int cyc = 0, n_chk = 0, n_fail = 0;

  mu_issue_ctl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_mulctl(req_mulctl), .req_rd(req_rd),
    .flush(flush), .mu_a(mu_a), .mu_b(mu_b), .mu_mulctl(mu_mulctl), .mu_res(mu_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [XLEN-1:0] ref_mul(input logic [XLEN-1:0] a, b, input logic [1:0] c);
    logic signed [2*XLEN:0] x, y, p;
    x = (c == MULHU) ? {(XLEN + 1)'(0), a} : {{(XLEN + 1){a[XLEN-1]}}, a};
    y = c[1] ? {(XLEN + 1)'(0), b} : {{(XLEN + 1){b[XLEN-1]}}, b};
    p = x * y;
    return (c == MUL_LO) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] pick();
    int r = $urandom_range(0, 7);
    return r == 0 ? '0 : r == 1 ? '1 : r == 2 ? {1'b1, (XLEN - 1)'(0)} :
           r == 3 ? {1'b0, {(XLEN - 1){1'b1}}} : XLEN'($urandom());
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural multiplier: MU_LAT register stages from the operand inputs to mulres
  always @(posedge clk) begin
    pipe[0] <= ref_mul(mu_a, mu_b, mu_mulctl);
    for (int i = 1; i < MU_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mu_res = pipe[MU_LAT-1];

  // Monitor: outstanding ops live in q in accept order; a response is due MU_LAT+2 cycles after accept
  always @(negedge clk) if (rst_n) begin
    ent_t e;
    check("req_ready", 64'(req_ready), 64'(!flush && q.size() < BUF_DEPTH));
    check("busy", 64'(busy), 64'(q.size() != 0));
    check("rsp_valid", 64'(rsp_valid), 64'(q.size() == 0 ? 1'b0 : (cyc - q[0].cyc >= MU_LAT + 2)));
    if (rsp_valid && rsp_ready && !flush && q.size() != 0) begin
      e = q.pop_front();
      check("rsp_data", 64'(rsp_data), 64'(e.d));
      check("rsp_rd", 64'(rsp_rd), 64'(e.rd));
      obs.push_back('{rsp_data, rsp_rd, cyc});
    end
    if (flush) q.delete();
    else if (req_valid && req_ready) q.push_back('{ref_mul(req_a, req_b, req_mulctl), req_rd, cyc});
  end

  task automatic send(input logic [XLEN-1:0] a, b, input logic [1:0] c, input logic [TAG_W-1:0] rd,
                      output int ac);
    int k = 0;
    req_valid = 1; req_a = a; req_b = b; req_mulctl = c; req_rd = rd; ac = -1;
    while (k < 50) begin
      @(negedge clk);
      if (req_ready) break;
      k++;
    end
    if (req_ready) ac = cyc;
    else check("send_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic wait_obs(input int n);
    int k = 0;
    while (obs.size() < n && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (obs.size() < n) check("wait_rsp_timeout", 64'(obs.size()), 64'(n));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ac, acc, base;
    rst_n = 0;
    #1;
    check("rst_mu_a", 64'(mu_a), 64'(0));
    check("rst_mu_b", 64'(mu_b), 64'(0));
    check("rst_mu_mulctl", 64'(mu_mulctl), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_data", 64'(rsp_data), 64'(0));
    check("rst_rsp_rd", 64'(rsp_rd), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    #21 rst_n = 1;
    #1 check("post_rst_req_ready", 64'(req_ready), 64'(1));
    @(posedge clk); #1;

    // Single MUL and its accept-to-response latency
    rsp_ready = 1;
    base = obs.size();
    send(32'hFFFFFFFD, 32'hFFFFFFFC, MUL_LO, 5'd5, ac);
    wait_obs(base + 1);
    if (obs.size() > base) begin
      check("mul_data", 64'(obs[base].d), 64'(12));
      check("mul_rd", 64'(obs[base].rd), 64'(5));
      check("mul_latency", 64'(obs[base].cyc - ac), 64'(MU_LAT + 2));
    end

    // Back-to-back high-half variants
    base = obs.size();
    send(32'hFFFFFFFD, 32'hFFFFFFFC, MULH, 5'd1, ac);
    send(32'hFFFFFFFD, 32'hFFFFFFFC, MULHSU, 5'd2, ac);
    send(32'hFFFFFFFD, 32'hFFFFFFFC, MULHU, 5'd3, ac);
    wait_obs(base + 3);
    if (obs.size() >= base + 3) begin
      check("mulh_data", 64'(obs[base].d), 64'(32'h00000000));
      check("mulhsu_data", 64'(obs[base+1].d), 64'(32'hFFFFFFFD));
      check("mulhu_data", 64'(obs[base+2].d), 64'(32'hFFFFFFF9));
      check("mulh_rd_order", 64'({obs[base].rd, obs[base+1].rd, obs[base+2].rd}), 64'({5'd1, 5'd2, 5'd3}));
      check("mulh_consecutive", 64'(obs[base+2].cyc - obs[base].cyc), 64'(2));
    end

    // Backpressure: credits run out at BUF_DEPTH outstanding
    rsp_ready = 0;
    acc = 0;
    base = obs.size();
    for (int i = 0; i < 10; i++) begin
      req_valid = 1; req_a = XLEN'($urandom()); req_b = XLEN'($urandom());
      req_mulctl = 2'($urandom_range(0, 3)); req_rd = TAG_W'(10 + acc);
      @(negedge clk);
      if (req_ready) acc++;
      @(posedge clk); #1;
    end
    check("bp_accepts", 64'(acc), 64'(BUF_DEPTH));
    check("bp_ready_low", 64'(req_ready), 64'(0));
    req_valid = 0;
    rsp_ready = 1;
    check("bp_ready_pop_cycle", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    check("bp_ready_after_pop", 64'(req_ready), 64'(1));
    wait_obs(base + BUF_DEPTH);
    for (int i = 0; i < BUF_DEPTH; i++)
      if (obs.size() > base + i) check("bp_order_rd", 64'(obs[base+i].rd), 64'(10 + i));

    // Flush one cycle after two accepts
    base = obs.size();
    send(32'd1, 32'd2, MUL_LO, 5'd20, ac);
    send(32'd3, 32'd4, MUL_LO, 5'd21, ac);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    check("flush_busy", 64'(busy), 64'(0));
    check("flush_rsp_valid", 64'(rsp_valid), 64'(0));
    send(32'd7, 32'd6, MUL_LO, 5'd9, ac);
    wait_obs(base + 1);
    repeat (5) @(posedge clk);
    #1;
    check("flush_rsp_count", 64'(obs.size()), 64'(base + 1));
    if (obs.size() > base) begin
      check("flush_next_data", 64'(obs[base].d), 64'(42));
      check("flush_next_rd", 64'(obs[base].rd), 64'(9));
    end

    // Random traffic with backpressure and occasional flush
    for (int i = 0; i < 3000; i++) begin
      req_valid = $urandom_range(0, 3) != 0;
      req_a = pick(); req_b = pick();
      req_mulctl = 2'($urandom_range(0, 3));
      req_rd = TAG_W'($urandom_range(0, 31));
      rsp_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 60) == 0;
      @(posedge clk); #1;
    end
    req_valid = 0; flush = 0; rsp_ready = 1;
    repeat (20) @(posedge clk);
    #1;
    check("drain_busy", 64'(busy), 64'(0));

    // Asynchronous reset with three results buffered
    rsp_ready = 0;
    send(32'd3, 32'd5, MUL_LO, 5'd1, ac);
    send(32'd4, 32'd5, MUL_LO, 5'd2, ac);
    send(32'd6, 32'd5, MUL_LO, 5'd3, ac);
    repeat (MU_LAT + 3) @(posedge clk);
    #1;
    check("pre_rst_rsp_valid", 64'(rsp_valid), 64'(1));
    rst_n = 0;
    q.delete();
    #1;
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("mid_rst_rsp_data", 64'(rsp_data), 64'(0));
    check("mid_rst_rsp_rd", 64'(rsp_rd), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_mu", 64'({mu_a, mu_b, mu_mulctl}), 64'(0));
    check("mid_rst_req_ready", 64'(req_ready), 64'(0));
    #2 rst_n = 1;
    rsp_ready = 1;
    base = obs.size();
    repeat (10) @(posedge clk);
    #1;
    check("rst_no_residual", 64'(obs.size()), 64'(base));
    send(32'd100, 32'hFFFFFFFF, MULHU, 5'd17, ac);
    wait_obs(base + 1);
    if (obs.size() > base) begin
      check("post_rst_data", 64'(obs[base].d), 64'(99));
      check("post_rst_rd", 64'(obs[base].rd), 64'(17));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
